// File: rtl/sram_pkg.sv
// Shared types and constants for the LC-3 SRAM target model.
package sram_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_IN_W = 20;

  localparam logic [DATA_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WR_ARM  = 2'd2,
    WR_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_responder_if.sv
// Controller-to-SRAM strobe bus: the controller is master, the memory model is slave.
interface sram_responder_if;
  import sram_pkg::*;

  logic [ADDR_IN_W-1:0] ADDR;
  logic [DATA_W-1:0]    Data_in;
  logic [DATA_W-1:0]    Data_out;
  logic                 Mem_CE;
  logic                 Mem_UB;
  logic                 Mem_LB;
  logic                 Mem_OE;
  logic                 Mem_WE;
  logic                 Data_valid;

  modport master (
    output ADDR, Data_in, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
    input  Data_out, Data_valid
  );

  modport slave (
    input  ADDR, Data_in, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
    output Data_out, Data_valid
  );

endinterface

// File: rtl/sram_responder_sync2.sv
// Two-flop synchronizer for slow asynchronous board inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Target-side model of the LC-3 asynchronous SRAM: registered reads, two-cycle
// qualified writes, and one memory-mapped I/O word (switches in, hex display out).
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 10,
  parameter logic [DATA_W-1:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_responder_if.slave   bus,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] Hex_out,
  output logic              Err_short_write
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LANE_W = DATA_W / 2;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic [DATA_W-1:0] hex_q, hex_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] sw_sync;
  logic [DATA_W-1:0] addr_c;
  logic [ADDR_W-1:0] idx_c;
  logic              is_io_c;
  logic              in_range_c;
  logic              wr_en_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] rd_raw_c;
  logic [DATA_W-1:0] rd_word_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Upper MAR bits are outside the decoded 16-bit space.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.ADDR[ADDR_IN_W-1:DATA_W];

  sync2 #(.WIDTH(DATA_W)) u_sw_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Switches),
    .q     (sw_sync)
  );

  assign addr_c     = bus.ADDR[DATA_W-1:0];
  assign idx_c      = addr_c[ADDR_W-1:0];
  assign is_io_c    = (addr_c == IO_ADDR);
  assign in_range_c = !is_io_c && (32'(addr_c) < DEPTH);
  assign mem_we_c   = wr_en_c && in_range_c;

  // Read mux: I/O word, array word, or zero for unmapped space; disabled lanes read 0.
  always_comb begin
    rd_raw_c = '0;
    if (is_io_c) begin
      rd_raw_c = sw_sync;
    end else if (in_range_c) begin
      rd_raw_c = mem[idx_c];
    end
    rd_word_c = rd_raw_c;
    if (bus.Mem_UB) rd_word_c[DATA_W-1:LANE_W] = '0;
    if (bus.Mem_LB) rd_word_c[LANE_W-1:0]      = '0;
  end

  // Next-state and registered-output logic; WE always wins over OE.
  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    hex_d        = hex_q;
    err_d        = err_q;
    wr_en_c      = 1'b0;

    if (bus.Mem_CE) begin
      state_d      = IDLE;
      data_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.Mem_WE) begin
            state_d      = WR_ARM;
            data_valid_d = 1'b0;
          end else if (!bus.Mem_OE) begin
            state_d      = READ;
            data_out_d   = rd_word_c;
            data_valid_d = 1'b1;
          end else begin
            data_valid_d = 1'b0;
          end
        end
        READ: begin
          if (!bus.Mem_WE) begin
            state_d      = WR_ARM;
            data_valid_d = 1'b0;
          end else if (!bus.Mem_OE) begin
            data_out_d   = rd_word_c;
            data_valid_d = 1'b1;
          end else begin
            state_d      = IDLE;
            data_valid_d = 1'b0;
          end
        end
        WR_ARM: begin
          data_valid_d = 1'b0;
          if (!bus.Mem_WE) begin
            wr_en_c = 1'b1;
            state_d = WR_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        WR_DONE: begin
          data_valid_d = 1'b0;
          if (bus.Mem_WE) state_d = IDLE;
        end
        default: begin
          state_d      = IDLE;
          data_valid_d = 1'b0;
        end
      endcase
    end

    if (wr_en_c && is_io_c) begin
      if (!bus.Mem_UB) hex_d[DATA_W-1:LANE_W] = bus.Data_in[DATA_W-1:LANE_W];
      if (!bus.Mem_LB) hex_d[LANE_W-1:0]      = bus.Data_in[LANE_W-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      hex_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      hex_q        <= hex_d;
      err_q        <= err_d;
    end
  end

  // Byte-lane array write; contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (mem_we_c && !bus.Mem_UB) mem[idx_c][DATA_W-1:LANE_W] <= bus.Data_in[DATA_W-1:LANE_W];
    if (mem_we_c && !bus.Mem_LB) mem[idx_c][LANE_W-1:0]      <= bus.Data_in[LANE_W-1:0];
  end

  assign bus.Data_out   = data_out_q;
  assign bus.Data_valid = data_valid_q;
  assign Hex_out        = hex_q;
  assign Err_short_write = err_q;

endmodule
